// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the MINAv2 pipeline sequencing controller: forwarding
// selects, the tracker entry layout and the forwarding priority helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd_addr;
    logic       is_load;
  } pipe_entry_t;

  localparam pipe_entry_t ENTRY_NONE = '{valid: 1'b0, rd_addr: 5'd0, is_load: 1'b0};

  function automatic logic entry_live(input pipe_entry_t e);
    return e.valid && (e.rd_addr != 5'd0);
  endfunction

  // match[0] is the EX producer (in MEM when the consumer reaches EX), match[1] the MEM producer.
  function automatic fwd_sel_e fwd_pick(input logic [1:0] match, input logic ex_is_load);
    fwd_sel_e sel;
    if (match[0]) begin
      sel = ex_is_load ? FWD_NONE : FWD_MEM;
    end else if (match[1]) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_match.sv
// Compares one ID source operand against the EX, MEM and WB tracker entries
// and reports a per-stage match vector (bit 0 = EX, 1 = MEM, 2 = WB).
module hazard_match
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0]  src_addr,
  input  logic        src_used,
  input  pipe_entry_t ex_entry,
  input  pipe_entry_t mem_entry,
  input  pipe_entry_t wb_entry,
  output logic [2:0]  match
);

  logic src_ok_s;
  logic unused_s;

  assign src_ok_s = src_used && (src_addr != 5'd0);

  assign match[0] = src_ok_s && entry_live(ex_entry)  && (ex_entry.rd_addr  == src_addr);
  assign match[1] = src_ok_s && entry_live(mem_entry) && (mem_entry.rd_addr == src_addr);
  assign match[2] = src_ok_s && entry_live(wb_entry)  && (wb_entry.rd_addr  == src_addr);

  // Load flags matter to the caller, not to the address compare.
  assign unused_s = ex_entry.is_load ^ mem_entry.is_load ^ wb_entry.is_load;

endmodule

// File: rtl/pipe_ctrl.sv
// MINAv2 pipeline sequencing controller: RAW hazard stall/bubble, branch flush,
// memory freeze and EX forwarding selects. Define PIPE_CTRL_FORWARDING_EN to enable forwarding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_ra_addr,
  input  logic [4:0] id_rb_addr,
  input  logic       id_ra_used,
  input  logic       id_rb_used,
  input  logic [4:0] id_rd_addr,
  input  logic       id_rd_we,
  input  logic       id_is_load,
  input  logic       branch_req,
  input  logic       mem_busy,
  output logic       if_stall,
  output logic       id_stall,
  output logic       ex_bubble,
  output logic       if_id_flush,
  output logic       freeze,
  output fwd_sel_e   fwd_a_sel,
  output fwd_sel_e   fwd_b_sel
);

  pipe_entry_t ex_r;
  pipe_entry_t mem_r;
  pipe_entry_t wb_r;
  pipe_entry_t id_entry_s;
  logic [2:0]  a_match_s;
  logic [2:0]  b_match_s;
  logic        hazard_s;
  logic        stall_s;
  fwd_sel_e    fwd_a_s;
  fwd_sel_e    fwd_b_s;

  assign id_entry_s = '{valid: id_valid & id_rd_we, rd_addr: id_rd_addr, is_load: id_is_load};

  hazard_match u_match_a (
    .src_addr  (id_ra_addr),
    .src_used  (id_ra_used),
    .ex_entry  (ex_r),
    .mem_entry (mem_r),
    .wb_entry  (wb_r),
    .match     (a_match_s)
  );

  hazard_match u_match_b (
    .src_addr  (id_rb_addr),
    .src_used  (id_rb_used),
    .ex_entry  (ex_r),
    .mem_entry (mem_r),
    .wb_entry  (wb_r),
    .match     (b_match_s)
  );

`ifdef PIPE_CTRL_FORWARDING_EN
  logic unused_s;
  // The WB producer has already left the bypass network.
  assign unused_s = a_match_s[2] ^ b_match_s[2];
`endif

  // Hazard detection and forwarding selection for the ID operands
  always_comb begin
`ifdef PIPE_CTRL_FORWARDING_EN
    hazard_s = id_valid && ex_r.is_load && (a_match_s[0] || b_match_s[0]);
    fwd_a_s  = id_valid ? fwd_pick(a_match_s[1:0], ex_r.is_load) : FWD_NONE;
    fwd_b_s  = id_valid ? fwd_pick(b_match_s[1:0], ex_r.is_load) : FWD_NONE;
`else
    hazard_s = id_valid && ((|a_match_s) || (|b_match_s));
    fwd_a_s  = FWD_NONE;
    fwd_b_s  = FWD_NONE;
`endif
    stall_s = mem_busy || hazard_s;
  end

  // Control outputs, held quiet while reset is asserted
  always_comb begin
    if (!rst_n) begin
      if_stall    = 1'b0;
      id_stall    = 1'b0;
      ex_bubble   = 1'b0;
      if_id_flush = 1'b0;
      freeze      = 1'b0;
      fwd_a_sel   = FWD_NONE;
      fwd_b_sel   = FWD_NONE;
    end else begin
      if_stall    = stall_s;
      id_stall    = stall_s;
      ex_bubble   = hazard_s && !mem_busy;
      if_id_flush = branch_req && id_valid && !stall_s;
      freeze      = mem_busy;
      fwd_a_sel   = fwd_a_s;
      fwd_b_sel   = fwd_b_s;
    end
  end

  // Tracker advance: hold on freeze, bubble into EX on stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_r  <= ENTRY_NONE;
      mem_r <= ENTRY_NONE;
      wb_r  <= ENTRY_NONE;
    end else if (!mem_busy) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      ex_r  <= (id_valid && !stall_s) ? id_entry_s : ENTRY_NONE;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MINAv2 core. It tracks in-flight destination registers in EX, MEM and WB, detects read-after-write hazards against the operands being decoded in ID, and generates the IF/ID stall, ID/EX bubble and IF/ID flush controls. It also generates operand forwarding selects for EX. It sits beside `id_stage` and drives the enables of the IF/ID, ID/EX and downstream pipeline registers.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset; one clock; synchronous, active-low
- `id_valid`  in  1  IF/ID holds a real instruction
- `id_ra_addr`, `id_rb_addr`  in  5  source register addresses decoded in ID
- `id_ra_used`, `id_rb_used`  in  1  source actually read (SEL_REG selected)
- `id_rd_addr`  in  5  destination decoded in ID
- `id_rd_we`  in  1  ID instruction writes `id_rd_addr`
- `id_is_load`  in  1  ID instruction is a load (result available after MEM)
- `branch_req`  in  1  ID resolved a taken BRA/CALL
- `mem_busy`  in  1  memory stage cannot complete this cycle
- `if_stall`  out  1  hold IA and IF/ID
- `id_stall`  out  1  hold ID operands
- `ex_bubble`  out  1  load a NOP into ID/EX
- `if_id_flush`  out  1  load a bubble into IF/ID
- `freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB
- `fwd_a_sel`, `fwd_b_sel`  out  2  `fwd_sel_e` operand source for EX

## Operation
- Tracker: three entries, EX, MEM and WB. Each entry holds {valid, rd_addr, is_load}. An entry is "live" when valid, rd write enabled and rd_addr != 0.
- Advance when `freeze`=0:
  - WB←MEM.
  - MEM←EX.
  - EX←ID entry when `id_valid & ~id_stall`; otherwise EX←invalid (bubble).
- `freeze` = `mem_busy`. While `freeze`=1:
  - all tracker entries hold;
  - `if_stall`=`id_stall`=1;
  - `ex_bubble`=`if_id_flush`=0.
- Hazard: a used source in ID matches a live entry.
  - Register 0 never hazards.
  - Only `id_valid` instructions hazard.
- On hazard:
  - `if_stall`=`id_stall`=`ex_bubble`=1;
  - ID instruction stays in place; EX receives a bubble.
- Branch: `if_id_flush` = `branch_req & id_valid & ~id_stall & ~freeze`. The branch itself advances into EX, so CALL writes r31 normally. The wrong-path fetch is discarded.
- Simultaneous hazard and `branch_req`: stall wins and the flush is suppressed until the stall clears. The branch re-asserts `branch_req` because ID holds.
- Forwarding priority: MEM entry (youngest producer) first, then WB, else `FWD_NONE`. A load entry is never a forwarding source from MEM.

## Timing
- All outputs are combinational from inputs and tracker state. There is no registered output latency.
- Reset (`rst_n`=0 at a rising edge):
  - all tracker entries become invalid;
  - while `rst_n`=0, all outputs are forced to 0 / `FWD_NONE`.
- Reset asserted mid-stall ends the stall on the next cycle. There is no replay.
- Load-use with forwarding: exactly 1 stall cycle. The consumer then reads `FWD_WB`.
- Without forwarding: a consumer issued right behind its producer stalls 3 cycles. The producer passes EX, MEM and WB; the register file has no write-through.
- `mem_busy` may last any number of cycles. Hazard evaluation resumes with unchanged state.

## Configuration
- `PIPE_CTRL_FORWARDING_EN` defined:
  - hazard = used source matches a live EX entry with `is_load`=1;
  - `fwd_*_sel` are active per the priority rules above.
- Not defined:
  - hazard = used source matches any live EX, MEM or WB entry;
  - `fwd_a_sel`/`fwd_b_sel` are tied to `FWD_NONE`.

## Structure
- `types` package:
  - `fwd_sel_e` (2 bits): `FWD_NONE`=0, `FWD_MEM`=1, `FWD_WB`=2;
  - `pipe_entry_t` struct {valid, rd_addr, is_load}.
- One sub-module: `hazard_match`. It compares one source address and used flag against the three entries. It returns per-stage match bits. It is instantiated twice (A, B).

## Test plan
- ADD r3 in EX, ID reads r3 on A:
  - forwarding: `fwd_a_sel`=`FWD_MEM`, no stall;
  - no forwarding: `id_stall` high for 3 cycles, then the consumer issues.
- Load to r5 in EX, ID reads r5 on B, forwarding: `id_stall`=`ex_bubble`=1 for 1 cycle, then `fwd_b_sel`=`FWD_WB`.
- Producer writes r0, ID reads r0: no stall, `fwd_*_sel`=`FWD_NONE`.
- `branch_req`=1 with no hazard: `if_id_flush`=1 for one cycle. The CALL entry with rd=31 appears in EX next cycle.
- `mem_busy` held 4 cycles during a load-use stall:
  - tracker unchanged throughout;
  - after release, exactly 1 further stall cycle.
- `rst_n`=0 for one edge while EX/MEM/WB are live: next cycle an ID read of those registers produces no stall and `FWD_NONE`.
